// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bus shared by NUM_REQ producers, the write arbiter and one FIFO write port.
// Handshake: a producer holds req[i]/its req_data slice stable until it sees gnt[i]; gnt[i]=1
// means that word is written into the FIFO at this clock edge, and gnt is never set while fifo_full.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 2
);
    localparam int OW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic                          fifo_full;
    logic                          fifo_wr;
    logic [DATA_WIDTH-1:0]         fifo_data;
    logic                          owner_valid;
    logic [OW-1:0]                 owner;

    modport master (
        output req, req_data, fifo_full,
        input  gnt, fifo_wr, fifo_data, owner_valid, owner
    );

    modport slave (
        input  req, req_data, fifo_full,
        output gnt, fifo_wr, fifo_data, owner_valid, owner
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter in front of a FIFO; a granted producer keeps ownership for up
// to MAX_BURST consecutive words. The FSM state is visible as owner_valid (1 exactly in BURST).
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 2,
    parameter int MAX_BURST  = 4
) (
    input logic              clk,
    input logic              rst,
    fifo_wr_arbiter_if.slave bus
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]         owner_q, owner_d;
    logic [CW-1:0]         burst_cnt_q, burst_cnt_d;
    logic                  owner_valid_q, owner_valid_d;
    logic [NUM_REQ-1:0]    gnt;
    logic                  cand_found;
    logic [PW-1:0]         cand_idx;
    logic [DATA_WIDTH-1:0] data_mux;

    // Explicit wrap so NUM_REQ need not be a power of two.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] i);
        if (int'(i) == NUM_REQ - 1) return '0;
        return i + 1'b1;
    endfunction

    always_comb begin
        int            idx;
        logic [PW-1:0] pos;
        idx        = 0;
        pos        = '0;
        cand_found = 1'b0;
        cand_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            pos = PW'(idx);
            if (!cand_found && bus.req[pos]) begin
                cand_found = 1'b1;
                cand_idx   = pos;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        gnt         = '0;
        case (state_q)
            IDLE: begin
                if (cand_found && !bus.fifo_full) begin
                    gnt[cand_idx] = 1'b1;
                    if (MAX_BURST > 1) begin
                        state_d     = BURST;
                        owner_d     = cand_idx;
                        burst_cnt_d = CW'(1);
                    end else begin
                        rr_ptr_d = wrap_inc(cand_idx);
                    end
                end
            end
            BURST: begin
                if (!bus.req[owner_q]) begin
                    // Owner let go: one bubble cycle, then arbitrate from the next producer.
                    state_d     = IDLE;
                    rr_ptr_d    = wrap_inc(owner_q);
                    owner_d     = '0;
                    burst_cnt_d = '0;
                end else if (!bus.fifo_full) begin
                    gnt[owner_q] = 1'b1;
                    if (burst_cnt_q + 1'b1 == CW'(MAX_BURST)) begin
                        state_d     = IDLE;
                        rr_ptr_d    = wrap_inc(owner_q);
                        owner_d     = '0;
                        burst_cnt_d = '0;
                    end else begin
                        burst_cnt_d = burst_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) gnt = '0;
        owner_valid_d = (state_d == BURST);
    end

    always_comb begin
        data_mux = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) data_mux = data_mux | bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            owner_q       <= '0;
            burst_cnt_q   <= '0;
            owner_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            owner_q       <= owner_d;
            burst_cnt_q   <= burst_cnt_d;
            owner_valid_q <= owner_valid_d;
        end
    end

    assign bus.gnt         = gnt;
    assign bus.fifo_wr     = |gnt;
    assign bus.fifo_data   = data_mux;
    assign bus.owner_valid = owner_valid_q;
    assign bus.owner       = owner_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios, random stimulus against an integer-level
// arbitration model, and a run against a behavioural 16-deep FIFO with producer queues.
module tb_fifo_wr_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(2)) if0 ();
    fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(2)) if1 ();

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(2), .MAX_BURST(4)) dut  (.clk(clk), .rst(rst), .bus(if0));
    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(2), .MAX_BURST(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    always #5 clk = ~clk;

    logic [3:0] gnt_o[2];
    logic       wr_o[2];
    logic [1:0] data_o[2];
    logic       ov_o[2];
    logic [1:0] owner_o[2];
    assign gnt_o[0] = if0.gnt;          assign gnt_o[1] = if1.gnt;
    assign wr_o[0] = if0.fifo_wr;       assign wr_o[1] = if1.fifo_wr;
    assign data_o[0] = if0.fifo_data;   assign data_o[1] = if1.fifo_data;
    assign ov_o[0] = if0.owner_valid;   assign ov_o[1] = if1.owner_valid;
    assign owner_o[0] = if0.owner;      assign owner_o[1] = if1.owner;

    // Reference model per DUT: owner (-1 = none), words used in this ownership, next search start.
    int   m_owner[2] = '{-1, -1};
    int   m_cnt[2]   = '{0, 0};
    int   m_ptr[2]   = '{0, 0};
    int   exp_g[2];
    logic exp_ov[2];
    int   exp_ow[2];

    task automatic model_step(input int w, input int mb, input logic [3:0] r, input logic f,
                              input logic rs, output int g);
        int c;
        g = -1;
        c = -1;
        if (rs) begin
            m_owner[w] = -1; m_cnt[w] = 0; m_ptr[w] = 0;
            return;
        end
        if (m_owner[w] < 0) begin
            for (int k = 0; k < 4; k++)
                if (c < 0 && ((r >> ((m_ptr[w] + k) % 4)) & 4'd1) != 0) c = (m_ptr[w] + k) % 4;
            if (c >= 0 && !f) begin
                g = c;
                if (mb > 1) begin m_owner[w] = c; m_cnt[w] = 1; end
                else m_ptr[w] = (c + 1) % 4;
            end
        end else if (((r >> m_owner[w]) & 4'd1) == 0) begin
            m_ptr[w] = (m_owner[w] + 1) % 4; m_owner[w] = -1; m_cnt[w] = 0;
        end else if (!f) begin
            g = m_owner[w];
            m_cnt[w]++;
            if (m_cnt[w] == mb) begin
                m_ptr[w] = (m_owner[w] + 1) % 4; m_owner[w] = -1; m_cnt[w] = 0;
            end
        end
    endtask

    function automatic logic [3:0] onehot(input int g);
        logic [3:0] one;
        one = 4'd1;
        return (g < 0) ? 4'd0 : (one << g);
    endfunction

    // Driver: apply inputs to both DUTs after the falling edge, compute model expectations for
    // the coming rising edge, then leave #1 for the caller to sample.
    task automatic drive(input logic [3:0] r, input logic [7:0] d, input logic f, input logic rs);
        int g;
        @(negedge clk);
        rst = rs;
        if0.req = r; if0.req_data = d; if0.fifo_full = f;
        if1.req = r; if1.req_data = d; if1.fifo_full = f;
        for (int w = 0; w < 2; w++) begin
            exp_ov[w] = (m_owner[w] >= 0);
            exp_ow[w] = exp_ov[w] ? m_owner[w] : 0;
            model_step(w, (w == 0) ? 4 : 1, r, f, rs, g);
            exp_g[w] = g;
        end
        #1;
    endtask

    task automatic test_reset();
        drive(4'b1111, 8'hE4, 1'b0, 1'b1);
        for (int w = 0; w < 2; w++) begin
            n_checks++;
            if (gnt_o[w] !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt dut%0d: got %b want 0000", w, gnt_o[w]); end
            n_checks++;
            if (wr_o[w] !== 1'b0) begin n_fail++; $display("FAIL reset_wr dut%0d: got %b want 0", w, wr_o[w]); end
        end
        drive(4'b1111, 8'hE4, 1'b0, 1'b1);
        for (int w = 0; w < 2; w++) begin
            n_checks++;
            if (ov_o[w] !== 1'b0) begin n_fail++; $display("FAIL reset_owner_valid dut%0d: got %b want 0", w, ov_o[w]); end
            n_checks++;
            if (owner_o[w] !== 2'd0) begin n_fail++; $display("FAIL reset_owner dut%0d: got %0d want 0", w, owner_o[w]); end
        end
    endtask

    task automatic test_rotation();
        int idx;
        drive(4'b0000, 8'h00, 1'b0, 1'b1);
        for (int c = 0; c < 20; c++) begin
            drive(4'b1111, 8'b11_10_01_00, 1'b0, 1'b0);
            idx = (c / 4) % 4;
            n_checks++;
            if (gnt_o[0] !== onehot(idx)) begin n_fail++; $display("FAIL rot_gnt c%0d: got %b want %b", c, gnt_o[0], onehot(idx)); end
            n_checks++;
            if (wr_o[0] !== 1'b1) begin n_fail++; $display("FAIL rot_wr c%0d: got %b want 1", c, wr_o[0]); end
            n_checks++;
            if (data_o[0] !== 2'(idx)) begin n_fail++; $display("FAIL rot_data c%0d: got %0d want %0d", c, data_o[0], idx); end
            n_checks++;
            if (ov_o[0] !== (c % 4 != 0)) begin n_fail++; $display("FAIL rot_owner_valid c%0d: got %b want %b", c, ov_o[0], (c % 4 != 0)); end
        end
    endtask

    task automatic test_release();
        drive(4'b0000, 8'h00, 1'b0, 1'b1);
        drive(4'b0100, 8'h20, 1'b0, 1'b0);
        n_checks++;
        if (gnt_o[0] !== 4'b0100) begin n_fail++; $display("FAIL rel_gnt1: got %b want 0100", gnt_o[0]); end
        drive(4'b0100, 8'h10, 1'b0, 1'b0);
        n_checks++;
        if (gnt_o[0] !== 4'b0100) begin n_fail++; $display("FAIL rel_gnt2: got %b want 0100", gnt_o[0]); end
        n_checks++;
        if (owner_o[0] !== 2'd2 || ov_o[0] !== 1'b1) begin n_fail++; $display("FAIL rel_owner: got %b/%0d want 1/2", ov_o[0], owner_o[0]); end
        drive(4'b0000, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if (gnt_o[0] !== 4'b0000 || ov_o[0] !== 1'b1) begin n_fail++; $display("FAIL rel_bubble: got gnt %b ov %b want 0000 1", gnt_o[0], ov_o[0]); end
        drive(4'b0101, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if (gnt_o[0] !== 4'b0001 || ov_o[0] !== 1'b0) begin n_fail++; $display("FAIL rel_wrap: got gnt %b ov %b want 0001 0", gnt_o[0], ov_o[0]); end
    endtask

    task automatic test_full_stall();
        drive(4'b0000, 8'h00, 1'b0, 1'b1);
        for (int c = 0; c < 2; c++) begin
            drive(4'b1010, 8'h00, 1'b0, 1'b0);
            n_checks++;
            if (gnt_o[0] !== 4'b0010) begin n_fail++; $display("FAIL stall_pre c%0d: got %b want 0010", c, gnt_o[0]); end
        end
        for (int c = 0; c < 3; c++) begin
            drive(4'b1010, 8'h00, 1'b1, 1'b0);
            n_checks++;
            if (gnt_o[0] !== 4'b0000 || wr_o[0] !== 1'b0) begin n_fail++; $display("FAIL stall_gnt c%0d: got %b/%b want 0000/0", c, gnt_o[0], wr_o[0]); end
            n_checks++;
            if (owner_o[0] !== 2'd1 || ov_o[0] !== 1'b1) begin n_fail++; $display("FAIL stall_owner c%0d: got %b/%0d want 1/1", c, ov_o[0], owner_o[0]); end
        end
        for (int c = 0; c < 2; c++) begin
            drive(4'b1010, 8'h00, 1'b0, 1'b0);
            n_checks++;
            if (gnt_o[0] !== 4'b0010) begin n_fail++; $display("FAIL stall_post c%0d: got %b want 0010", c, gnt_o[0]); end
        end
        drive(4'b1010, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if (gnt_o[0] !== 4'b1000) begin n_fail++; $display("FAIL stall_rotate: got %b want 1000", gnt_o[0]); end
    endtask

    task automatic test_mid_reset();
        drive(4'b0000, 8'h00, 1'b0, 1'b1);
        for (int c = 0; c < 2; c++) begin
            drive(4'b1000, 8'h00, 1'b0, 1'b0);
            n_checks++;
            if (gnt_o[0] !== 4'b1000) begin n_fail++; $display("FAIL mrst_pre c%0d: got %b want 1000", c, gnt_o[0]); end
        end
        drive(4'b1000, 8'h00, 1'b0, 1'b1);
        n_checks++;
        if (gnt_o[0] !== 4'b0000 || wr_o[0] !== 1'b0) begin n_fail++; $display("FAIL mrst_gnt: got %b/%b want 0000/0", gnt_o[0], wr_o[0]); end
        drive(4'b1010, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if (ov_o[0] !== 1'b0) begin n_fail++; $display("FAIL mrst_owner_valid: got %b want 0", ov_o[0]); end
        n_checks++;
        if (gnt_o[0] !== 4'b0010) begin n_fail++; $display("FAIL mrst_first: got %b want 0010", gnt_o[0]); end
    endtask

    task automatic test_single_burst();
        drive(4'b0000, 8'h00, 1'b0, 1'b1);
        for (int c = 0; c < 8; c++) begin
            drive(4'b1111, 8'b11_10_01_00, 1'b0, 1'b0);
            n_checks++;
            if (gnt_o[1] !== onehot(c % 4)) begin n_fail++; $display("FAIL mb1_gnt c%0d: got %b want %b", c, gnt_o[1], onehot(c % 4)); end
            n_checks++;
            if (ov_o[1] !== 1'b0) begin n_fail++; $display("FAIL mb1_owner_valid c%0d: got %b want 0", c, ov_o[1]); end
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic [7:0] d;
        logic [1:0] exp_d;
        for (int c = 0; c < 300; c++) begin
            r = 4'($urandom_range(0, 15));
            d = 8'($urandom);
            drive(r, d, $urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0);
            for (int w = 0; w < 2; w++) begin
                exp_d = (exp_g[w] < 0) ? 2'd0 : 2'(d >> (exp_g[w] * 2));
                n_checks++;
                if (gnt_o[w] !== onehot(exp_g[w]) || wr_o[w] !== (exp_g[w] >= 0) || data_o[w] !== exp_d) begin
                    n_fail++;
                    $display("FAIL rand_grant dut%0d c%0d: got %b/%b/%0d want %b/%b/%0d", w, c,
                             gnt_o[w], wr_o[w], data_o[w], onehot(exp_g[w]), exp_g[w] >= 0, exp_d);
                end
                n_checks++;
                if (ov_o[w] !== exp_ov[w] || owner_o[w] !== 2'(exp_ow[w])) begin
                    n_fail++;
                    $display("FAIL rand_owner dut%0d c%0d: got %b/%0d want %b/%0d", w, c, ov_o[w], owner_o[w], exp_ov[w], exp_ow[w]);
                end
            end
        end
    endtask

    task automatic test_fifo_integration();
        logic [1:0] src_q[4][$];
        logic [3:0] exp_q[$];
        logic [3:0] fifo_q[$];
        logic [3:0] r, got, want;
        logic [7:0] d;
        logic       full, done;
        int         grants, popped;
        grants = 0; popped = 0; done = 1'b0;
        for (int p = 0; p < 4; p++)
            for (int k = 0; k < 12; k++) src_q[p].push_back(2'($urandom));
        drive(4'b0000, 8'h00, 1'b0, 1'b1);
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            r = '0; d = '0;
            for (int p = 0; p < 4; p++)
                if (src_q[p].size() > 0) begin
                    r[p] = 1'b1;
                    d = d | (8'(src_q[p][0]) << (2 * p));
                end
            full = (fifo_q.size() >= 16);
            drive(r, d, full, 1'b0);
            n_checks++;
            if (!$onehot0(gnt_o[0]) || (full && gnt_o[0] != 4'b0000) || gnt_o[0] !== onehot(exp_g[0])) begin
                n_fail++;
                $display("FAIL int_grant cyc%0d: got %b full %b want %b", cyc, gnt_o[0], full, onehot(exp_g[0]));
            end
            if (cyc % 8 == 7 && fifo_q.size() > 0) begin
                got = fifo_q.pop_front();
                want = exp_q.pop_front();
                popped++;
                n_checks++;
                if (got !== want) begin n_fail++; $display("FAIL int_order pop%0d: got %h want %h", popped, got, want); end
            end
            for (int p = 0; p < 4; p++)
                if (gnt_o[0][p] && src_q[p].size() > 0) begin
                    exp_q.push_back({2'(p), src_q[p][0]});
                    fifo_q.push_back({2'(p), data_o[0]});
                    void'(src_q[p].pop_front());
                    grants++;
                end
            done = (fifo_q.size() == 0);
            for (int p = 0; p < 4; p++) if (src_q[p].size() > 0) done = 1'b0;
        end
        n_checks++;
        if (!done) begin n_fail++; $display("FAIL int_timeout: got done=0 want done=1"); end
        n_checks++;
        if (popped != grants || grants != 48) begin n_fail++; $display("FAIL int_count: got popped %0d grants %0d want 48/48", popped, grants); end
    endtask

    initial begin
        if0.req = '0; if0.req_data = '0; if0.fifo_full = 1'b0;
        if1.req = '0; if1.req_data = '0; if1.fifo_full = 1'b0;
        test_reset();
        test_rotation();
        test_release();
        test_full_stall();
        test_mid_reset();
        test_single_burst();
        test_random();
        test_fifo_integration();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end
endmodule
